// File: rtl/logic_result_fifo_if.sv
// rtl/logic_result_fifo_if.sv - producer/consumer handshake bundle for logic_result_fifo
interface logic_result_fifo_if #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_sel;
   logic [DATA_W-1:0] in_result;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [2:0]        out_sel;
   logic              out_zero;
   logic              out_neg;
   logic              out_parity;
   logic              out_inval;
   logic [CW-1:0]     count;

   modport slave (
      input  in_valid, in_sel, in_result, out_ready,
      output in_ready, out_valid, out_result, out_sel,
             out_zero, out_neg, out_parity, out_inval, count
   );

   modport master (
      output in_valid, in_sel, in_result, out_ready,
      input  in_ready, out_valid, out_result, out_sel,
             out_zero, out_neg, out_parity, out_inval, count
   );
endinterface

// File: rtl/logic_result_fifo.sv
// rtl/logic_result_fifo.sv - result FIFO with write-time status flags for the logic unit
module logic_result_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input logic                clk,
   input logic                rst_n,
   logic_result_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [2:0]        sel;
      logic [DATA_W-1:0] result;
      logic              zero;
      logic              neg;
      logic              parity;
      logic              inval;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   entry_t        wr_entry;
   entry_t        head;

   // Handshake readiness comes from the registered count only, so no ready-to-ready path exists.
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign push  = bus.in_valid & ~full;
   assign pop   = bus.out_ready & ~empty;

   always_comb begin
      wr_entry        = '0;
      wr_entry.sel    = bus.in_sel;
      wr_entry.result = bus.in_result;
      wr_entry.zero   = (bus.in_result == '0);
      wr_entry.neg    = bus.in_result[DATA_W-1];
      wr_entry.parity = ^bus.in_result;
      wr_entry.inval  = (bus.in_sel == 3'b111);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_entry;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      head = mem[rd_ptr];
      if (empty) begin
         head = '0;
      end
   end

   assign bus.in_ready   = ~full;
   assign bus.out_valid  = ~empty;
   assign bus.out_result = head.result;
   assign bus.out_sel    = head.sel;
   assign bus.out_zero   = head.zero;
   assign bus.out_neg    = head.neg;
   assign bus.out_parity = head.parity;
   assign bus.out_inval  = head.inval;
   assign bus.count      = count;
endmodule

// File: tb/tb_logic_result_fifo.sv
// tb/tb_logic_result_fifo.sv - scoreboard bench for logic_result_fifo
module tb_logic_result_fifo;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;

   typedef struct {
      logic [2:0]  sel;
      logic [15:0] res;
      bit          zero;
      bit          neg;
      bit          parity;
      bit          inval;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int          n_checks = 0;
   int          n_fail   = 0;
   exp_t        sb[$];
   logic [15:0] got[$];
   int          mcount = 0;
   bit          acc    = 1'b0;
   bit          mon_en = 1'b0;

   logic_result_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   logic_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [2:0] s, input logic [15:0] r);
      exp_t e;
      e.sel    = s;
      e.res    = r;
      e.zero   = (r == 16'd0);
      e.neg    = (r >= 16'h8000);
      e.parity = (($countones(r) % 2) == 1);
      e.inval  = (s == 3'd7);
      return e;
   endfunction

   // Reference model: occupancy and accepted writes, decided from the pre-edge state.
   always @(posedge clk) begin
      bit do_push;
      bit do_pop;
      if (!rst_n) begin
         sb.delete();
         mcount = 0;
         acc    = 1'b0;
      end else begin
         do_push = bus.in_valid && (mcount < DEPTH);
         do_pop  = bus.out_ready && (mcount > 0);
         if (do_push) sb.push_back(mk(bus.in_sel, bus.in_result));
         mcount = mcount + int'(do_push) - int'(do_pop);
         acc    = do_push;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("count", 32'(bus.count), 32'(mcount));
         chk("count_bound", 32'(bus.count <= 3'd4), 32'd1);
         chk("in_ready", 32'(bus.in_ready), 32'(mcount < DEPTH));
         chk("out_valid", 32'(bus.out_valid), 32'(mcount > 0));
         if (mcount > 0 && sb.size() > 0) begin
            e = sb[0];
            chk("out_result", 32'(bus.out_result), 32'(e.res));
            chk("out_sel", 32'(bus.out_sel), 32'(e.sel));
            chk("out_flags", 32'({bus.out_zero, bus.out_neg, bus.out_parity, bus.out_inval}),
                32'({e.zero, e.neg, e.parity, e.inval}));
            if (bus.out_ready) begin
               void'(sb.pop_front());
               if (rst_n) got.push_back(e.res);
            end
         end else if (mcount == 0) begin
            chk("empty_outputs", 32'({bus.out_result, bus.out_sel, bus.out_zero, bus.out_neg,
                bus.out_parity, bus.out_inval}), 32'd0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [2:0] s, input logic [15:0] r, input bit rdy);
      bus.in_valid  = v;
      bus.in_sel    = s;
      bus.in_result = r;
      bus.out_ready = rdy;
   endtask

   task automatic drain();
      drive(1'b0, 3'd0, 16'd0, 1'b1);
      for (int i = 0; i < 20 && mcount > 0; i++) step();
      chk("drain_count", 32'(bus.count), 32'd0);
      bus.out_ready = 1'b0;
   endtask

   task automatic fill(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, 3'(i), base + 16'(i), 1'b0);
         step();
      end
      drive(1'b0, 3'd0, 16'd0, 1'b0);
   endtask

   logic [15:0] fv [4] = '{16'h0000, 16'h8001, 16'h00FF, 16'hFFFF};
   logic [2:0]  fs [4] = '{3'd0, 3'd1, 3'd2, 3'd7};
   logic [3:0]  ft [4] = '{4'b1000, 4'b0100, 4'b0000, 4'b0101};

   initial begin
      int pushed;
      int cyc;
      int n;

      drive(1'b1, 3'd5, 16'hAAAA, 1'b0);
      rst_n = 1'b0;
      step();
      mon_en = 1'b1;
      step();
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_result", 32'(bus.out_result), 32'd0);

      rst_n = 1'b1;
      drive(1'b1, 3'd3, 16'h1234, 1'b0);
      step();
      drive(1'b0, 3'd0, 16'd0, 1'b0);
      chk("first_push_valid", 32'(bus.out_valid), 32'd1);
      chk("first_push_result", 32'(bus.out_result), 32'h1234);
      drain();

      for (int i = 0; i < 4; i++) begin
         drive(1'b1, fs[i], fv[i], 1'b0);
         step();
      end
      chk("fill_count", 32'(bus.count), 32'd4);
      chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
      drive(1'b1, 3'd4, 16'hDEAD, 1'b0);
      step();
      chk("fifth_push_count", 32'(bus.count), 32'd4);
      drive(1'b0, 3'd0, 16'd0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk("drain_result", 32'(bus.out_result), 32'(fv[i]));
         chk("drain_flags", 32'({bus.out_zero, bus.out_neg, bus.out_parity, bus.out_inval}),
             32'(ft[i]));
         step();
      end
      chk("after_fill_drain_valid", 32'(bus.out_valid), 32'd0);

      got.delete();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 3'(i % 7), 16'h0100 + 16'(i), 1'b1);
         step();
         chk("stream_count", 32'(bus.count), 32'd1);
      end
      drain();
      chk("stream_len", 32'(got.size()), 32'd20);
      for (int i = 0; i < 20 && i < got.size(); i++)
         chk("stream_order", 32'(got[i]), 32'h0100 + 32'(i));

      fill(4, 16'h2000);
      drive(1'b1, 3'd6, 16'hBEEF, 1'b1);
      chk("full_pop_in_ready", 32'(bus.in_ready), 32'd0);
      step();
      chk("full_pop_count", 32'(bus.count), 32'd3);
      chk("full_pop_ready_next", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b0;
      step();
      chk("refill_count", 32'(bus.count), 32'd4);
      drain();

      for (int r = 0; r < 3; r++) begin
         n = (r == 2) ? 4 : 3;
         pushed = 0;
         cyc = 0;
         drive(1'b1, 3'($urandom), 16'($urandom), 1'b0);
         while (pushed < n && cyc < 300) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
            cyc++;
            if (acc) begin
               pushed++;
               bus.in_sel    = 3'($urandom);
               bus.in_result = 16'($urandom);
            end
            bus.in_valid = (pushed < n);
         end
         chk("wrap_no_timeout", 32'(cyc < 300), 32'd1);
         drain();
      end

      fill(3, 16'h3000);
      chk("mid_count", 32'(bus.count), 32'd3);
      rst_n = 1'b0;
      drive(1'b1, 3'd1, 16'h5555, 1'b1);
      step();
      rst_n = 1'b1;
      drive(1'b0, 3'd0, 16'd0, 1'b0);
      chk("mid_rst_count", 32'(bus.count), 32'd0);
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      step();
      step();
      chk("mid_rst_stale_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_stale_result", 32'(bus.out_result), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
